// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and sizing helper for the multiply/divide unit
// Contents:
//   op_e      : operation codes driven on the unit's op port
//   state_e   : sequencer states
//   cnt_width : width of the step counter for a given operand width
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    // One extra bit so the counter can hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_unit_twos_mag.sv
// rtl/muldiv_unit_twos_mag.sv - conditional two's-complement negate
// Ports:
//   val_i : input value
//   neg_i : 1 = return -val_i, 0 = pass val_i through
//   res_o : result
module twos_mag #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? ((~val_i) + WIDTH'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide with HI/LO registers
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start, op, a, b      : launch request, operation code and operands (sampled in IDLE)
//   flush                : abandon any in-flight operation, no result written
//   hi_we, lo_we, wdata  : mthi/mtlo writes, honoured only while idle
//   busy                 : operation in flight
//   done                 : one-cycle pulse when HI/LO hold a fresh result
//   dbz                  : divide-by-zero flag of the last completed operation
//   hi, lo               : architectural HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_q, a_d;           // original dividend for the /0 result
    logic               is_div_q, is_div_d;
    logic               sign_q, sign_d;     // product / quotient sign
    logic               rsign_q, rsign_d;   // remainder sign
    logic               bz_q, bz_d;         // divisor was zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               op_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   new_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);

    twos_mag #(.WIDTH(WIDTH)) u_mag_a (
        .val_i (a),
        .neg_i (op_signed & a[WIDTH-1]),
        .res_o (mag_a)
    );

    twos_mag #(.WIDTH(WIDTH)) u_mag_b (
        .val_i (b),
        .neg_i (op_signed & b[WIDTH-1]),
        .res_o (mag_b)
    );

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right, keeping the carry.
    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Restoring step: the shifted remainder is one bit wider than the divisor,
    // so the borrow out of bit WIDTH decides the quotient bit.
    assign shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, mcand_q};
    assign q_bit    = ~diff[WIDTH];
    assign new_rem  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign div_next = {new_rem, acc_q[WIDTH-2:0], q_bit};

    twos_mag #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val_i (acc_q),
        .neg_i (sign_q),
        .res_o (prod_fix)
    );

    twos_mag #(.WIDTH(WIDTH)) u_fix_quo (
        .val_i (acc_q[WIDTH-1:0]),
        .neg_i (sign_q),
        .res_o (quo_fix)
    );

    twos_mag #(.WIDTH(WIDTH)) u_fix_rem (
        .val_i (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i (rsign_q),
        .res_o (rem_fix)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        rsign_d  = rsign_q;
        bz_d     = bz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !flush) begin
                    is_div_d = op[1];
                    sign_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rsign_d  = op_signed & a[WIDTH-1];
                    bz_d     = (b == '0);
                    a_d      = a;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = RUN;
                    if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        mcand_d = mag_b;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        mcand_d = mag_a;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!flush) begin
                    done_d = 1'b1;
                    dbz_d  = is_div_q & bz_q;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (bz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
            bz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            rsign_q  <= rsign_d;
            bz_q     <= bz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference model using native 64-bit and int arithmetic.
    function automatic exp_t model(input logic [1:0] op_m, input logic [W-1:0] am,
                                   input logic [W-1:0] bm);
        exp_t        e;
        logic [63:0] p;
        int          qa;
        int          qb;
        qa    = am;
        qb    = bm;
        e.dbz = 1'b0;
        e.hi  = '0;
        e.lo  = '0;
        case (op_m)
            2'b00: begin
                p    = $signed({{32{am[31]}}, am}) * $signed({{32{bm[31]}}, bm});
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p    = {32'b0, am} * {32'b0, bm};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b10: begin
                if (bm == 0) begin
                    e.hi = am; e.lo = '1; e.dbz = 1'b1;
                end else if (am == 32'h8000_0000 && bm == 32'hFFFF_FFFF) begin
                    e.hi = '0; e.lo = 32'h8000_0000;
                end else begin
                    e.lo = qa / qb;
                    e.hi = qa % qb;
                end
            end
            default: begin
                if (bm == 0) begin
                    e.hi = am; e.lo = '1; e.dbz = 1'b1;
                end else begin
                    e.lo = am / bm;
                    e.hi = am % bm;
                end
            end
        endcase
        return e;
    endfunction

    task automatic push_exp(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.dbz = d;
        sb.push_back(e);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Drive start for the current cycle (cycle 0); returns at cycle 1.
    task automatic launch(input logic [1:0] op_l, input logic [W-1:0] a_l,
                          input logic [W-1:0] b_l);
        op    = op_l;
        a     = a_l;
        b     = b_l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done timeout: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    // Scoreboard: every done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (done === 1'b1 && busy === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL done_busy_overlap: done=1 busy=1, required busy=0");
            end
            if (done === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: hi=%h lo=%h, no result expected", hi, lo);
                end else begin
                    mon_e = sb.pop_front();
                    if (hi !== mon_e.hi || lo !== mon_e.lo || dbz !== mon_e.dbz) begin
                        n_err++;
                        $display("FAIL result: got hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b",
                                 hi, lo, dbz, mon_e.hi, mon_e.lo, mon_e.dbz);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h, required all 0",
                     busy, done, dbz, hi, lo);
        end
    endtask

    task automatic test_mult_latency;
        int bad;
        bad = 0;
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        for (int c = 1; c <= W + 1; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (c != W + 1) tick();
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL mult_busy_window: %0d cycles in 1..%0d wrong, required busy=1 done=0",
                     bad, W + 1);
        end
        tick();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mult_done_cycle: done=%b busy=%b in cycle %0d, required done=1 busy=0",
                     done, busy, W + 2);
        end
    endtask

    task automatic test_back_to_back;
        push_exp(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back_accept: busy=%b, required 1", busy);
        end
        wait_done();
        push_exp(32'h0, 32'h8000_0000, 1'b0);
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
    endtask

    task automatic test_dbz;
        int n;
        n = 0;
        push_exp(32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        launch(OP_DIVU, 32'd100, 32'd0);
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_vec++;
        if (n != W + 1) begin
            n_err++;
            $display("FAIL dbz_latency: done in cycle %0d, required %0d", n + 1, W + 2);
        end
        tick();
        n_vec++;
        if (dbz !== 1'b1) begin
            n_err++;
            $display("FAIL dbz_hold: dbz=%b, required 1", dbz);
        end
        push_exp(32'h0, 32'd6, 1'b0);
        launch(OP_MULT, 32'd2, 32'd3);
        wait_done();
    endtask

    task automatic test_flush;
        tick();
        lo_we = 1'b1; wdata = 32'h1234;
        tick();
        lo_we = 1'b0; hi_we = 1'b1; wdata = 32'h5678;
        tick();
        hi_we = 1'b0;
        n_vec++;
        if (hi !== 32'h5678 || lo !== 32'h1234) begin
            n_err++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h, required hi=5678 lo=1234", hi, lo);
        end
        // flush together with start in IDLE: start ignored
        op = OP_MULT; a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_start_idle: busy=%b, required 0", busy);
        end
        launch(OP_MULT, 32'd5, 32'd5);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h5678 || lo !== 32'h1234 || dbz !== 1'b0) begin
            n_err++;
            $display("FAIL flush_abort: busy=%b done=%b hi=%h lo=%h dbz=%b, required 0 0 5678 1234 0",
                     busy, done, hi, lo, dbz);
        end
        repeat (40) tick();
        push_exp(32'h0, 32'd25, 1'b0);
        launch(OP_MULT, 32'd5, 32'd5);
        repeat (3) tick();
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        hi_we = 1'b0;
        n_vec++;
        if (hi !== 32'h5678) begin
            n_err++;
            $display("FAIL mthi_while_busy: hi=%h, required 5678", hi);
        end
        wait_done();
    endtask

    task automatic test_reset_mid;
        launch(OP_DIVU, 32'd9, 32'd4);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_err++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, required all 0",
                     busy, done, hi, lo);
        end
        push_exp(32'd1, 32'd2, 1'b0);
        launch(OP_DIVU, 32'd9, 32'd4);
        wait_done();
    endtask

    task automatic test_random;
        logic [1:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        exp_t         e;
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom);
            r_a  = $urandom;
            r_b  = $urandom;
            case (i % 6)
                1: r_b = '0;
                2: r_b = '1;
                3: r_a = 32'h8000_0000;
                4: r_b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            e = model(r_op, r_a, r_b);
            sb.push_back(e);
            launch(r_op, r_a, r_b);
            // starts while busy must be ignored
            repeat (4) begin
                start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
                tick();
            end
            start = 1'b0;
            wait_done();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        tick();
        test_reset();
        test_mult_latency();
        test_back_to_back();
        test_dbz();
        test_flush();
        test_reset_mid();
        test_random();
        repeat (3) tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
